lav_operand_feeder: RTL and testbench

LAV_OPERAND_FEEDER -- requirements
Module: lav_operand_feeder

---
 rtl/lav_operand_feeder.sv | 173 +++++++++++++++++
 tb/tb_lav_operand_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lav_operand_feeder.sv
// Operand-pair feeder: buffers upstream pairs and presents each to the IP top for a fixed hold time.
// Optional macro LAV_FEEDER_DONE_WAIT_EN adds a WAIT state that waits for lav_done (8-cycle timeout).
module lav_operand_feeder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic       upf_clk,
    input  logic       lav_reset,
    input  logic       lav_s_valid,
    output logic       lav_s_ready,
    input  logic [7:0] lav_s_op1,
    input  logic [7:0] lav_s_op2,
    input  logic       lav_s_c,
    output logic [7:0] lav_in1,
    output logic [7:0] lav_in2,
    output logic       lav_c,
    output logic       lav_en,
    input  logic       lav_done,
    output logic       lav_busy,
    output logic [3:0] lav_level
);

    localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1
`ifdef LAV_FEEDER_DONE_WAIT_EN
        , WAIT = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       level_q, level_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       in1_q, in1_d;
    logic [7:0]       in2_q, in2_d;
    logic             c_q, c_d;
    logic             en_q, en_d;
    logic [16:0]      mem_q [FIFO_DEPTH];
    logic [16:0]      head;
    logic             push;
    logic             pop;
    logic             finish;
    logic             empty;

`ifdef LAV_FEEDER_DONE_WAIT_EN
    logic [2:0] wcnt_q, wcnt_d;
`else
    logic unused_done;
    assign unused_done = lav_done;
`endif

    // No bypass: readiness depends only on the registered level.
    assign lav_s_ready = (level_q != DEPTH_L);
    assign push        = lav_s_valid & lav_s_ready & ~lav_reset;
    assign empty       = (level_q == 4'd0);
    assign head        = mem_q[rd_ptr_q];

    assign lav_in1   = in1_q;
    assign lav_in2   = in2_q;
    assign lav_c     = c_q;
    assign lav_en    = en_q;
    assign lav_busy  = (state_q != IDLE);
    assign lav_level = level_q;

    always_ff @(posedge upf_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {lav_s_c, lav_s_op2, lav_s_op1};
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        c_d      = c_q;
        en_d     = en_q;
        pop      = 1'b0;
        finish   = 1'b0;
`ifdef LAV_FEEDER_DONE_WAIT_EN
        wcnt_d   = wcnt_q;
`endif
        case (state_q)
            IDLE: finish = 1'b1;
            HOLD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
`ifdef LAV_FEEDER_DONE_WAIT_EN
                    state_d = WAIT;
                    en_d    = 1'b1;
                    wcnt_d  = 3'd0;
`else
                    finish  = 1'b1;
`endif
                end
            end
`ifdef LAV_FEEDER_DONE_WAIT_EN
            WAIT: begin
                // wcnt_q == 7 marks the eighth WAIT cycle.
                if (lav_done || (wcnt_q == 3'd7)) begin
                    finish = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // End of a presentation (or idling): issue the next pair back-to-back, else go idle.
        if (finish) begin
            if (!empty) begin
                pop = 1'b1;
            end else begin
                state_d = IDLE;
                en_d    = 1'b1;
            end
        end

        if (pop) begin
            in1_d    = head[7:0];
            in2_d    = head[15:8];
            c_d      = head[16];
            en_d     = 1'b0;
            cnt_d    = HOLD_LOAD;
            state_d  = HOLD;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign level_d  = level_q + {3'b000, push} - {3'b000, pop};

    always_ff @(posedge upf_clk or posedge lav_reset) begin
        if (lav_reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 4'd0;
            cnt_q    <= 4'd0;
            in1_q    <= 8'd0;
            in2_q    <= 8'd0;
            c_q      <= 1'b0;
            en_q     <= 1'b1;
`ifdef LAV_FEEDER_DONE_WAIT_EN
            wcnt_q   <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            c_q      <= c_d;
            en_q     <= en_d;
`ifdef LAV_FEEDER_DONE_WAIT_EN
            wcnt_q   <= wcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_lav_operand_feeder.sv
// Self-checking bench for lav_operand_feeder against a pair-queue / hold-time reference model.
module tb_lav_operand_feeder;
    localparam int DEPTH = 4;
    localparam int HOLD  = 3;

    logic       upf_clk;
    logic       lav_reset;
    logic       lav_s_valid;
    logic       lav_s_ready;
    logic [7:0] lav_s_op1;
    logic [7:0] lav_s_op2;
    logic       lav_s_c;
    logic [7:0] lav_in1;
    logic [7:0] lav_in2;
    logic       lav_c;
    logic       lav_en;
    logic       lav_done;
    logic       lav_busy;
    logic [3:0] lav_level;

    lav_operand_feeder #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .upf_clk(upf_clk), .lav_reset(lav_reset),
        .lav_s_valid(lav_s_valid), .lav_s_ready(lav_s_ready),
        .lav_s_op1(lav_s_op1), .lav_s_op2(lav_s_op2), .lav_s_c(lav_s_c),
        .lav_in1(lav_in1), .lav_in2(lav_in2), .lav_c(lav_c), .lav_en(lav_en),
        .lav_done(lav_done), .lav_busy(lav_busy), .lav_level(lav_level)
    );

    initial upf_clk = 1'b0;
    always #5 upf_clk = ~upf_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued pairs, cycles of presentation left, and done-wait progress.
    logic [16:0] exp_q[$];
    int          hold_left;
    bit          waiting;
    int          wcnt;
    logic [7:0]  m_in1;
    logic [7:0]  m_in2;
    logic        m_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hold_left = 0;
        waiting   = 0;
        wcnt      = 0;
        m_in1     = 8'd0;
        m_in2     = 8'd0;
        m_c       = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [16:0] pair);
        int          sz;
        bit          accept;
        bit          finish;
        logic [16:0] h;
        sz     = exp_q.size();
        accept = v && (sz != DEPTH);
        finish = 0;
        if (hold_left > 1) begin
            hold_left--;
        end else if (hold_left == 1) begin
            hold_left = 0;
`ifdef LAV_FEEDER_DONE_WAIT_EN
            waiting = 1;
            wcnt    = 0;
`else
            finish = 1;
`endif
        end
`ifdef LAV_FEEDER_DONE_WAIT_EN
        else if (waiting) begin
            if (lav_done || wcnt == 7) begin
                waiting = 0;
                finish  = 1;
            end else begin
                wcnt++;
            end
        end
`endif
        else begin
            finish = 1;
        end
        if (finish && sz > 0) begin
            h         = exp_q.pop_front();
            m_in1     = h[7:0];
            m_in2     = h[15:8];
            m_c       = h[16];
            hold_left = HOLD;
        end
        if (accept) exp_q.push_back(pair);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_in1"}, 32'(lav_in1), 32'(m_in1));
        chk({tag, "_in2"}, 32'(lav_in2), 32'(m_in2));
        chk({tag, "_c"}, 32'(lav_c), 32'(m_c));
        chk({tag, "_en"}, 32'(lav_en), (hold_left == 0) ? 32'd1 : 32'd0);
        chk({tag, "_busy"}, 32'(lav_busy), (hold_left > 0 || waiting) ? 32'd1 : 32'd0);
        chk({tag, "_level"}, 32'(lav_level), 32'(exp_q.size()));
        chk({tag, "_ready"}, 32'(lav_s_ready), (exp_q.size() != DEPTH) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic d);
        lav_s_valid = v;
        lav_s_op1   = a;
        lav_s_op2   = b;
        lav_s_c     = c;
        lav_done    = d;
        @(posedge upf_clk);
        model_edge(v, {c, b, a});
        #1;
        check_all("step");
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rand_push();
        step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        bit saw_full;
        bit found;
        int gap;

        lav_reset   = 1'b1;
        lav_s_valid = 1'b0;
        lav_s_op1   = 8'h00;
        lav_s_op2   = 8'h00;
        lav_s_c     = 1'b0;
        lav_done    = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        lav_reset = 1'b0;

        // Single pair: latency and exact hold length.
        step(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0);
        chk("single_accept_level", 32'(lav_level), 32'd1);
        chk("single_not_yet_en", 32'(lav_en), 32'd1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("single_in1", 32'(lav_in1), 32'hA5);
        chk("single_in2", 32'(lav_in2), 32'h3C);
        chk("single_c", 32'(lav_c), 32'd1);
        chk("single_en_low", 32'(lav_en), 32'd0);
        idle_steps(2);
        chk("single_en_still_low", 32'(lav_en), 32'd0);
        idle_steps(1);
        chk("single_en_back", 32'(lav_en), 32'd1);
        chk("single_held_in1", 32'(lav_in1), 32'hA5);
        idle_steps(3);

        // Back-to-back pushes until the buffer fills and stalls upstream.
        saw_full = 0;
        for (int i = 0; i < 12; i++) begin
            rand_push();
            if (!lav_s_ready) saw_full = 1;
        end
        chk("fill_saw_full", 32'(saw_full), 32'd1);
        idle_steps(40);

        // Continuous pushes while issuing.
        gap = 0;
        for (int i = 0; i < 30; i++) begin
            rand_push();
            if (i >= 2 && lav_en) gap++;
        end
`ifndef LAV_FEEDER_DONE_WAIT_EN
        chk("continuous_no_en_gap", 32'(gap), 32'd0);
`endif
        idle_steps(40);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom_range(0, 5) == 0));
        end
        idle_steps(60);

        // Reset in the second cycle of a hold with three pairs queued.
        for (int i = 0; i < 5; i++) rand_push();
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (hold_left == HOLD - 1 && exp_q.size() == 3) begin
                found = 1;
                break;
            end
            idle_steps(1);
        end
        chk("reach_mid_hold", 32'(found), 32'd1);
        #2;
        lav_reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        lav_s_valid = 1'b1;
        @(posedge upf_clk);
        #1;
        check_all("reset_no_push");
        lav_reset = 1'b0;
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        chk("post_reset_level", 32'(lav_level), 32'd1);
        idle_steps(1);
        chk("post_reset_issue_in1", 32'(lav_in1), 32'h11);
        idle_steps(20);
        chk("post_reset_drained", 32'(lav_level), 32'd0);

`ifdef LAV_FEEDER_DONE_WAIT_EN
        // Done pulse two cycles into WAIT, then a full timeout.
        step(1'b1, 8'h01, 8'h02, 1'b1, 1'b0);
        step(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
        found = 0;
        for (int k = 0; k < 30; k++) begin
            if (waiting && wcnt == 2) begin
                found = 1;
                break;
            end
            idle_steps(1);
        end
        chk("reach_wait2", 32'(found), 32'd1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("done_issue_en", 32'(lav_en), 32'd0);
        chk("done_issue_in1", 32'(lav_in1), 32'h03);
        idle_steps(HOLD + 7);
        chk("timeout_still_wait", 32'(lav_busy), 32'd1);
        idle_steps(1);
        chk("timeout_idle", 32'(lav_busy), 32'd0);
        idle_steps(5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
